ram_rd_arb: RTL
===============

RAM_RD_ARB -- requirements
Module: ram_rd_arb

Interface
REQ-001 SHALL have parameter RAM_LAT, default 1, giving RAM read latency in cycles; legal values 1 and 2.
REQ-002 SHALL have parameter STARVE_LIM, default 4, giving the maximum consecutive AXI grants while a buffer request is pending.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports buf0_rd_vld / buf1_rd_vld, input, 1 bit each: read request from RAM buffer 0/1.
REQ-006 SHALL have ports buf0_rd_addr / buf1_rd_addr, input, 8 bits each: RAM row for that request.
REQ-007 SHALL have ports buf0_rd_rdy / buf1_rd_rdy, output, 1 bit each: request accepted this cycle.
REQ-008 SHALL have ports axi_rd_vld, input, 1 bit; axi_rd_addr, input, 8 bits; axi_rd_rdy, output, 1 bit: AXI slave read request.
REQ-009 SHALL have ports ram_rd_en, output, 1 bit; ram_rd_addr, output, 8 bits: RAM read port.
REQ-010 SHALL have port ram_rd_data, input, 128 bits: RAM data, valid RAM_LAT cycles after ram_rd_en.
REQ-011 SHALL have ports buf0_alloc_vld / buf1_alloc_vld, output, 1 bit; buf0_alloc_addr / buf1_alloc_addr, output, 8 bits; buf0_alloc_data / buf1_alloc_data, output, 128 bits: return path into each buffer's alloc interface.
REQ-012 SHALL have ports axi_rsp_vld, output, 1 bit; axi_rsp_data, output, 128 bits: AXI read return.

Function
REQ-013 SHALL grant at most one requester per cycle; ram_rd_en = OR of the three rdy outputs; ram_rd_addr = granted address; the grant is combinational in the same cycle.
REQ-014 SHALL give AXI priority over both buffers, subject to REQ-020.
REQ-015 SHALL arbitrate buf0 vs buf1 round-robin: rr_ptr points to the preferred buffer, flips to the other after a buffer grant, and is unchanged when no buffer is granted.
REQ-016 A requester SHALL hold vld and addr stable until its rdy is high.
REQ-017 Each grant SHALL push {id, addr} into a RAM_LAT-deep tag pipeline; when the tag emerges, the matching *_alloc_vld / axi_rsp_vld SHALL pulse for 1 cycle with ram_rd_data and the stored addr.
REQ-018 Non-selected return outputs SHALL drive 0 for data and addr, so the results can be OR-combined downstream.
REQ-019 Back-to-back grants SHALL be supported at full throughput: one response per cycle, in grant order.
REQ-020 With the starvation feature enabled, starve_cnt (3 bits, saturating) SHALL increment on each AXI grant while any buffer vld is high, and clear on any buffer grant or when no buffer vld is high; at starve_cnt == STARVE_LIM the pending buffer SHALL win over AXI.
REQ-021 When no request is present, ram_rd_en SHALL be 0 and ram_rd_addr SHALL be 0.

Reset
REQ-022 On rst_n = 0 at a clock edge, the following SHALL clear: the tag pipeline valids, rr_ptr (to buf0), and starve_cnt.
REQ-023 All registered outputs SHALL be 0 in the cycle after reset.
REQ-024 A reset mid-operation SHALL drop in-flight responses with no response pulse afterwards.
REQ-025 No output SHALL be X during reset.

Configuration
REQ-026 Macro RAM_RD_ARB_STARVE_EN SHALL control the starvation feature: defined, REQ-020 applies; undefined, starve_cnt is absent and AXI has strict priority.

Structure
REQ-027 The define.vh constants SHALL be: requester IDs RD_ID_BUF0 = 2'd0, RD_ID_BUF1 = 2'd1, RD_ID_AXI = 2'd2, and the STARVE_LIM default.
REQ-028 The tag pipeline SHALL be the sub-module ram_rd_rsp_pipe, parameterised by RAM_LAT, built from DFFRE.

Verification
REQ-029 Scenario: buf0 alone reads addr 0x10 with RAM_LAT=1 -> buf0_rd_rdy high the same cycle; buf0_alloc_vld 1 cycle later with addr 0x10 and data equal to RAM[0x10].
REQ-030 Scenario: buf0 and buf1 held vld for 4 cycles -> grants alternate buf0, buf1, buf0, buf1.
REQ-031 Scenario: AXI vld continuously and buf1 vld, macro defined -> 4 AXI grants, then 1 buf1 grant; with the macro undefined -> buf1 never granted.
REQ-032 Scenario: RAM_LAT=2 with a burst of 3 grants AXI, buf0, buf1 -> responses arrive in that order on cycles +2, +3, +4.
REQ-033 Scenario: rst_n low for 1 cycle with 2 reads in flight -> no alloc_vld or rsp_vld afterwards, and the next grant goes to buf0.

Source files
------------

// File: rtl/ram_rd_arb_pkg.sv
// Shared types and constants for the RAM read arbiter and its response tag pipeline.
package ram_rd_arb_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DATA_W         = 128;
    localparam int unsigned STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {
        RD_ID_BUF0 = 2'd0,
        RD_ID_BUF1 = 2'd1,
        RD_ID_AXI  = 2'd2
    } rd_id_e;

    typedef struct packed {
        rd_id_e              id;
        logic [ADDR_W-1:0]   addr;
    } rd_tag_t;

endpackage

// File: rtl/ram_rd_rsp_pipe.sv
// RAM_LAT-deep tag pipeline: carries {id, addr} of each grant alongside the RAM read.
module ram_rd_rsp_pipe
    import ram_rd_arb_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_vld,
    input  rd_tag_t push_tag,
    output logic    pop_vld,
    output rd_tag_t pop_tag
);

    logic [RAM_LAT-1:0] vld_q, vld_d;
    rd_tag_t            tag_q [RAM_LAT];
    rd_tag_t            tag_d [RAM_LAT];

    // Each stage is a reset/enable flop: the tag only loads when a valid entry moves in.
    always_comb begin
        vld_d    = '0;
        tag_d    = tag_q;
        vld_d[0] = push_vld;
        if (push_vld) tag_d[0] = push_tag;
        for (int unsigned i = 1; i < RAM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign pop_vld = vld_q[RAM_LAT-1];
    assign pop_tag = tag_q[RAM_LAT-1];

endmodule

// File: rtl/ram_rd_arb.sv
// RAM read arbiter: AXI over two round-robin buffers, with tagged response return.
// Optional AXI starvation limit enabled by defining RAM_RD_ARB_STARVE_EN.
module ram_rd_arb
    import ram_rd_arb_pkg::*;
#(
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                buf0_rd_vld,
    input  logic [ADDR_W-1:0]   buf0_rd_addr,
    output logic                buf0_rd_rdy,
    input  logic                buf1_rd_vld,
    input  logic [ADDR_W-1:0]   buf1_rd_addr,
    output logic                buf1_rd_rdy,
    input  logic                axi_rd_vld,
    input  logic [ADDR_W-1:0]   axi_rd_addr,
    output logic                axi_rd_rdy,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data,
    output logic                buf0_alloc_vld,
    output logic [ADDR_W-1:0]   buf0_alloc_addr,
    output logic [DATA_W-1:0]   buf0_alloc_data,
    output logic                buf1_alloc_vld,
    output logic [ADDR_W-1:0]   buf1_alloc_addr,
    output logic [DATA_W-1:0]   buf1_alloc_data,
    output logic                axi_rsp_vld,
    output logic [DATA_W-1:0]   axi_rsp_data
);

    if (RAM_LAT < 1 || RAM_LAT > 2 || STARVE_LIM > 7) begin : g_bad_param
        $error("ram_rd_arb: RAM_LAT must be 1 or 2 and STARVE_LIM must fit 3 bits");
    end

    logic    rr_ptr_q, rr_ptr_d;
    logic    starve_hit;
    logic    push_vld, pop_vld;
    rd_tag_t push_tag, pop_tag;

`ifdef RAM_RD_ARB_STARVE_EN
    logic       buf_pend;
    logic [2:0] starve_cnt_q, starve_cnt_d;

    assign buf_pend   = buf0_rd_vld | buf1_rd_vld;
    assign starve_hit = buf_pend && (starve_cnt_q == 3'(STARVE_LIM));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (axi_rd_rdy && buf_pend) begin
            if (starve_cnt_q != 3'd7) starve_cnt_d = starve_cnt_q + 3'd1;
        end else if (buf0_rd_rdy || buf1_rd_rdy || !buf_pend) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        axi_rd_rdy  = 1'b0;
        buf0_rd_rdy = 1'b0;
        buf1_rd_rdy = 1'b0;
        if (axi_rd_vld && !starve_hit) begin
            axi_rd_rdy = 1'b1;
        end else if (buf0_rd_vld && buf1_rd_vld) begin
            buf0_rd_rdy = ~rr_ptr_q;
            buf1_rd_rdy = rr_ptr_q;
        end else begin
            buf0_rd_rdy = buf0_rd_vld;
            buf1_rd_rdy = buf1_rd_vld;
        end

        // Pointer moves to the buffer that was not just served.
        rr_ptr_d = rr_ptr_q;
        if (buf0_rd_rdy)      rr_ptr_d = 1'b1;
        else if (buf1_rd_rdy) rr_ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    always_comb begin
        ram_rd_addr   = '0;
        push_tag.id   = RD_ID_BUF0;
        if (axi_rd_rdy) begin
            ram_rd_addr = axi_rd_addr;
            push_tag.id = RD_ID_AXI;
        end else if (buf1_rd_rdy) begin
            ram_rd_addr = buf1_rd_addr;
            push_tag.id = RD_ID_BUF1;
        end else if (buf0_rd_rdy) begin
            ram_rd_addr = buf0_rd_addr;
        end
        push_tag.addr = ram_rd_addr;
    end

    assign ram_rd_en = axi_rd_rdy | buf0_rd_rdy | buf1_rd_rdy;
    assign push_vld  = ram_rd_en;

    ram_rd_rsp_pipe #(
        .RAM_LAT (RAM_LAT)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_tag (push_tag),
        .pop_vld  (pop_vld),
        .pop_tag  (pop_tag)
    );

    // Unselected return lanes stay zero so downstream can OR them together.
    always_comb begin
        buf0_alloc_vld  = 1'b0;
        buf0_alloc_addr = '0;
        buf0_alloc_data = '0;
        buf1_alloc_vld  = 1'b0;
        buf1_alloc_addr = '0;
        buf1_alloc_data = '0;
        axi_rsp_vld     = 1'b0;
        axi_rsp_data    = '0;
        if (pop_vld) begin
            case (pop_tag.id)
                RD_ID_BUF0: begin
                    buf0_alloc_vld  = 1'b1;
                    buf0_alloc_addr = pop_tag.addr;
                    buf0_alloc_data = ram_rd_data;
                end
                RD_ID_BUF1: begin
                    buf1_alloc_vld  = 1'b1;
                    buf1_alloc_addr = pop_tag.addr;
                    buf1_alloc_data = ram_rd_data;
                end
                RD_ID_AXI: begin
                    axi_rsp_vld  = 1'b1;
                    axi_rsp_data = ram_rd_data;
                end
                default: ;
            endcase
        end
    end

endmodule
